// File: rtl/sync_bus_qualifier.sv
// Qualifies a synchronized multi-bit bus: a value must hold for STABLE_CYCLES
// matching samples before it is committed and queued on a valid/ready output.
module sync_bus_qualifier #(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] stable_val,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW = PW + 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_QUAL = CW'(STABLE_CYCLES - 1);
   localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

   logic [WIDTH-1:0] prevQ;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic [NW-1:0]    count;

   logic match;
   logic qualify;
   logic push;
   logic pop;
   logic full;
   logic wrEn;

   // The saturating counter makes qualify fire on exactly one edge per stable run.
   assign match     = (sync_in == prevQ);
   assign qualify   = match && (cnt == CNT_QUAL);
   assign push      = qualify && (sync_in != stable_val);
   assign out_valid = (count != '0);
   assign full      = (count == COUNT_FULL);
   assign pop       = out_valid && out_ready;
   assign wrEn      = push && (!full || pop);
   assign out_data  = out_valid ? mem[rdPtr] : '0;

   // Qualification state, FIFO bookkeeping and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prevQ      <= '0;
         cnt        <= '0;
         stable_val <= '0;
         rdPtr      <= '0;
         wrPtr      <= '0;
         count      <= '0;
         overflow   <= 1'b0;
      end else begin
         prevQ <= sync_in;

         if (!match) begin
            cnt <= '0;
         end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (push) begin
            stable_val <= sync_in;
         end

         if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end

         case ({wrEn, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // A dropped push takes priority over a clear on the same edge.
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // Storage needs no reset: out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrPtr] <= sync_in;
      end
   end

endmodule

// File: tb/tb_sync_bus_qualifier.sv
// Scoreboard bench for sync_bus_qualifier: a default build and a
// STABLE_CYCLES=1 / FIFO_DEPTH=2 build share one clock and reset.
module tb_sync_bus_qualifier;

   logic       clk;
   logic       rst;

   logic [7:0] syncA;
   logic [7:0] dataA;
   logic       validA;
   logic       readyA;
   logic [7:0] stableA;
   logic       ovfA;
   logic       clrA;

   logic [7:0] syncB;
   logic [7:0] dataB;
   logic       validB;
   logic       readyB;
   logic [7:0] stableB;
   logic       ovfB;
   logic       clrB;

   int checks = 0;
   int errors = 0;

   logic [7:0] qA [$];
   logic [7:0] qB [$];

   sync_bus_qualifier dutA (
      .clk       (clk),
      .rst       (rst),
      .sync_in   (syncA),
      .out_data  (dataA),
      .out_valid (validA),
      .out_ready (readyA),
      .stable_val(stableA),
      .overflow  (ovfA),
      .clr_ovf   (clrA)
   );

   sync_bus_qualifier #(.WIDTH(8), .STABLE_CYCLES(1), .FIFO_DEPTH(2)) dutB (
      .clk       (clk),
      .rst       (rst),
      .sync_in   (syncB),
      .out_data  (dataB),
      .out_valid (validB),
      .out_ready (readyB),
      .stable_val(stableB),
      .overflow  (ovfB),
      .clr_ovf   (clrB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] value, input bit expectA, input int cycles);
      syncA = value;
      if (expectA) qA.push_back(value);
      tick(cycles);
   endtask

   task automatic applyStimulusB(input logic [7:0] value, input int cycles);
      syncB = value;
      qB.push_back(value);
      tick(cycles);
   endtask

   // Every accepted head is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst && validA && readyA) begin
         if (qA.size() != 0) checkOutput("sbA_pop", {24'b0, dataA}, {24'b0, qA.pop_front()});
         else checkOutput("sbA_unexpected", {24'b0, dataA}, 32'h100);
      end
      if (rst && validB && readyB) begin
         if (qB.size() != 0) checkOutput("sbB_pop", {24'b0, dataB}, {24'b0, qB.pop_front()});
         else checkOutput("sbB_unexpected", {24'b0, dataB}, 32'h100);
      end
   end

   initial begin
      rst = 1'b0;
      syncA = 8'h00; readyA = 1'b1; clrA = 1'b0;
      syncB = 8'h00; readyB = 1'b1; clrB = 1'b0;
      #2;
      checkOutput("reset_validA", {31'b0, validA}, 32'h0);
      checkOutput("reset_dataA", {24'b0, dataA}, 32'h0);
      tick(3);
      rst = 1'b1;
      tick(4);
      checkOutput("idle_zero_no_push", {31'b0, validA}, 32'h0);

      // Latency: push lands on the third edge after the change.
      syncA = 8'h5A; qA.push_back(8'h5A);
      tick(1); checkOutput("lat_e1_valid", {31'b0, validA}, 32'h0);
      tick(1); checkOutput("lat_e2_valid", {31'b0, validA}, 32'h0);
      tick(1); checkOutput("lat_e3_valid", {31'b0, validA}, 32'h1);
      checkOutput("lat_e3_data", {24'b0, dataA}, 32'h5A);
      checkOutput("lat_e3_stable", {24'b0, stableA}, 32'h5A);
      tick(1); checkOutput("lat_e4_valid", {31'b0, validA}, 32'h0);

      // Single-cycle glitch must be ignored.
      applyStimulus(8'h7F, 1'b0, 1);
      applyStimulus(8'h5A, 1'b0, 5);
      checkOutput("glitch_stable", {24'b0, stableA}, 32'h5A);
      checkOutput("glitch_valid", {31'b0, validA}, 32'h0);
      applyStimulus(8'h7F, 1'b1, 4);
      checkOutput("glitch_commit", {24'b0, stableA}, 32'h7F);

      // Backpressure: fill, then drop one.
      readyA = 1'b0;
      applyStimulus(8'h11, 1'b1, 4);
      applyStimulus(8'h22, 1'b1, 4);
      applyStimulus(8'h33, 1'b1, 4);
      applyStimulus(8'h44, 1'b1, 4);
      checkOutput("full_valid", {31'b0, validA}, 32'h1);
      checkOutput("full_head", {24'b0, dataA}, 32'h11);
      checkOutput("full_no_ovf", {31'b0, ovfA}, 32'h0);
      applyStimulus(8'h55, 1'b0, 4);
      checkOutput("drop_ovf", {31'b0, ovfA}, 32'h1);
      checkOutput("drop_stable", {24'b0, stableA}, 32'h55);
      checkOutput("drop_head", {24'b0, dataA}, 32'h11);

      // Push and pop on the same edge while full.
      syncA = 8'h66; qA.push_back(8'h66);
      tick(2);
      readyA = 1'b1;
      tick(1);
      readyA = 1'b0;
      checkOutput("pp_head", {24'b0, dataA}, 32'h22);
      checkOutput("pp_ovf", {31'b0, ovfA}, 32'h1);
      checkOutput("pp_stable", {24'b0, stableA}, 32'h66);

      // Clear coinciding with another dropped push: set wins.
      syncA = 8'h77;
      tick(2);
      clrA = 1'b1;
      tick(1);
      clrA = 1'b0;
      checkOutput("setwins_ovf", {31'b0, ovfA}, 32'h1);
      checkOutput("setwins_stable", {24'b0, stableA}, 32'h77);
      clrA = 1'b1;
      tick(1);
      clrA = 1'b0;
      checkOutput("clr_ovf", {31'b0, ovfA}, 32'h0);

      readyA = 1'b1;
      tick(6);
      checkOutput("drain_empty", {31'b0, validA}, 32'h0);
      checkOutput("drain_data_zero", {24'b0, dataA}, 32'h0);

      // Asynchronous reset mid-stream with buffered entries and overflow set.
      readyA = 1'b0;
      applyStimulus(8'h81, 1'b0, 4);
      applyStimulus(8'h82, 1'b0, 4);
      applyStimulus(8'h83, 1'b0, 4);
      applyStimulus(8'h84, 1'b0, 4);
      applyStimulus(8'h85, 1'b0, 4);
      checkOutput("prerst_valid", {31'b0, validA}, 32'h1);
      checkOutput("prerst_ovf", {31'b0, ovfA}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_valid", {31'b0, validA}, 32'h0);
      checkOutput("rst_data", {24'b0, dataA}, 32'h0);
      checkOutput("rst_stable", {24'b0, stableA}, 32'h0);
      checkOutput("rst_ovf", {31'b0, ovfA}, 32'h0);
      syncA = 8'h00;
      tick(2);
      rst = 1'b1;
      readyA = 1'b1;
      tick(5);
      checkOutput("postrst_valid", {31'b0, validA}, 32'h0);

      // Second build: one matching sample qualifies, two-entry buffer.
      syncB = 8'h3C; qB.push_back(8'h3C);
      tick(1); checkOutput("B_lat_e1_valid", {31'b0, validB}, 32'h0);
      tick(1); checkOutput("B_lat_e2_valid", {31'b0, validB}, 32'h1);
      checkOutput("B_lat_e2_data", {24'b0, dataB}, 32'h3C);
      tick(1);
      for (int r = 0; r < 4; r++) begin
         readyB = 1'b0;
         applyStimulusB(8'(8'h10 + 2 * r), 3);
         applyStimulusB(8'(8'h11 + 2 * r), 3);
         checkOutput("B_full_head", {24'b0, dataB}, {24'b0, 8'(8'h10 + 2 * r)});
         checkOutput("B_full_ovf", {31'b0, ovfB}, 32'h0);
         readyB = 1'b1;
         tick(3);
         checkOutput("B_round_empty", {31'b0, validB}, 32'h0);
      end

      checkOutput("sbA_left", qA.size(), 32'h0);
      checkOutput("sbB_left", qB.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
